// File: rtl/exec_page_tracker.sv
// rtl/exec_page_tracker.sv - tracker of executable pages with CAM lookup.
// Handles insert, full flush, per-ASID sweep and PPN invalidation.
module exec_page_tracker #(
  parameter int PPN_W     = 20,
  parameter int N         = 16,
  parameter int ASID_W    = 9,
  parameter int NQ        = 2,
  parameter int MEGA_BITS = 10,
  localparam int PA_W     = PPN_W + 12,
  localparam int IDX_W    = $clog2(N),
  localparam int CNT_W    = $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ins_valid_i,
  output logic                 ins_ready_o,
  input  logic [PPN_W-1:0]     ins_ppn_i,
  input  logic [ASID_W-1:0]    ins_asid_i,
  input  logic                 ins_mega_i,
  input  logic                 ins_global_i,
  input  logic                 flush_all_i,
  input  logic                 flush_asid_valid_i,
  output logic                 flush_asid_ready_o,
  input  logic [ASID_W-1:0]    flush_asid_i,
  input  logic                 inv_valid_i,
  input  logic [PPN_W-1:0]     inv_ppn_i,
  input  logic [NQ*PA_W-1:0]   q_pa_i,
  input  logic [NQ*ASID_W-1:0] q_asid_i,
  output logic [NQ-1:0]        q_hit_o,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     count_o
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        valid_q, valid_d;
  logic [PPN_W-1:0]    ppn_q  [N];
  logic [PPN_W-1:0]    ppn_d  [N];
  logic [ASID_W-1:0]   asid_q [N];
  logic [ASID_W-1:0]   asid_d [N];
  logic [N-1:0]        mega_q, mega_d;
  logic [N-1:0]        glob_q, glob_d;
  logic [IDX_W-1:0]    victim_q, victim_d;
  logic [IDX_W-1:0]    sweep_idx_q, sweep_idx_d;
  logic [ASID_W-1:0]   sweep_asid_q, sweep_asid_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                ins_fire, fl_fire, dup, free_found;
  logic [IDX_W-1:0]    free_idx, tgt_idx;

  // Megapage entries compare only the PPN bits above MEGA_BITS.
  function automatic logic ppn_eq(input logic [PPN_W-1:0] a, input logic [PPN_W-1:0] b,
                                  input logic mega);
    if (mega) return a[PPN_W-1:MEGA_BITS] == b[PPN_W-1:MEGA_BITS];
    return a == b;
  endfunction

  always_comb begin
    q_hit_o = '0;
    for (int k = 0; k < NQ; k++) begin
      for (int i = 0; i < N; i++) begin
        if (valid_q[i] && (glob_q[i] || asid_q[i] == q_asid_i[k*ASID_W +: ASID_W]) &&
            ppn_eq(ppn_q[i], q_pa_i[k*PA_W+12 +: PPN_W], mega_q[i]))
          q_hit_o[k] = 1'b1;
      end
    end
  end

  assign ins_ready_o        = (state_q == IDLE) && !flush_all_i && !flush_asid_valid_i && !inv_valid_i;
  assign flush_asid_ready_o = (state_q == IDLE) && !flush_all_i;
  assign ins_fire           = ins_valid_i && ins_ready_o;
  assign fl_fire            = flush_asid_valid_i && flush_asid_ready_o;
  assign busy_o             = (state_q == SWEEP);
  assign count_o            = count_q;

  always_comb begin
    dup        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_q[i] && ppn_q[i] == ins_ppn_i && asid_q[i] == ins_asid_i &&
          mega_q[i] == ins_mega_i && glob_q[i] == ins_global_i)
        dup = 1'b1;
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    tgt_idx = free_found ? free_idx : victim_q;
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    ppn_d        = ppn_q;
    asid_d       = asid_q;
    mega_d       = mega_q;
    glob_d       = glob_q;
    victim_d     = victim_q;
    sweep_idx_d  = sweep_idx_q;
    sweep_asid_d = sweep_asid_q;
    count_d      = '0;

    if (fl_fire) begin
      state_d      = SWEEP;
      sweep_idx_d  = '0;
      sweep_asid_d = flush_asid_i;
    end

    if (state_q == SWEEP) begin
      if (valid_q[sweep_idx_q] && !glob_q[sweep_idx_q] && asid_q[sweep_idx_q] == sweep_asid_q)
        valid_d[sweep_idx_q] = 1'b0;
      if (sweep_idx_q == IDX_W'(N-1)) state_d = IDLE;
      else sweep_idx_d = sweep_idx_q + 1'b1;
    end

    if (ins_fire && !dup) begin
      valid_d[tgt_idx] = 1'b1;
      ppn_d[tgt_idx]   = ins_ppn_i;
      asid_d[tgt_idx]  = ins_asid_i;
      mega_d[tgt_idx]  = ins_mega_i;
      glob_d[tgt_idx]  = ins_global_i;
      if (!free_found) victim_d = victim_q + 1'b1;
    end

    // Invalidation ignores ASID and global so a written exec page is never left stale.
    if (inv_valid_i) begin
      for (int i = 0; i < N; i++)
        if (valid_q[i] && ppn_eq(ppn_q[i], inv_ppn_i, mega_q[i])) valid_d[i] = 1'b0;
    end

    if (flush_all_i) begin
      valid_d     = '0;
      state_d     = IDLE;
      victim_d    = '0;
      sweep_idx_d = '0;
    end

    for (int i = 0; i < N; i++) count_d = count_d + CNT_W'(valid_d[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      mega_q       <= '0;
      glob_q       <= '0;
      victim_q     <= '0;
      sweep_idx_q  <= '0;
      sweep_asid_q <= '0;
      count_q      <= '0;
      for (int i = 0; i < N; i++) begin
        ppn_q[i]  <= '0;
        asid_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mega_q       <= mega_d;
      glob_q       <= glob_d;
      victim_q     <= victim_d;
      sweep_idx_q  <= sweep_idx_d;
      sweep_asid_q <= sweep_asid_d;
      count_q      <= count_d;
      ppn_q        <= ppn_d;
      asid_q       <= asid_d;
    end
  end

endmodule

// File: tb/tb_exec_page_tracker.sv
// tb/tb_exec_page_tracker.sv - directed self-checking bench for exec_page_tracker.
module tb_exec_page_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_valid = 1'b0, ins_ready;
  logic [19:0] ins_ppn = '0;
  logic [8:0]  ins_asid = '0;
  logic        ins_mega = 1'b0, ins_global = 1'b0;
  logic        flush_all = 1'b0;
  logic        flush_asid_valid = 1'b0, flush_asid_ready;
  logic [8:0]  flush_asid = '0;
  logic        inv_valid = 1'b0;
  logic [19:0] inv_ppn = '0;
  logic [63:0] q_pa = '0;
  logic [17:0] q_asid = '0;
  logic [1:0]  q_hit;
  logic        busy;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;
  int cyc;

  exec_page_tracker dut (
    .clk(clk), .rst(rst),
    .ins_valid_i(ins_valid), .ins_ready_o(ins_ready),
    .ins_ppn_i(ins_ppn), .ins_asid_i(ins_asid), .ins_mega_i(ins_mega), .ins_global_i(ins_global),
    .flush_all_i(flush_all),
    .flush_asid_valid_i(flush_asid_valid), .flush_asid_ready_o(flush_asid_ready),
    .flush_asid_i(flush_asid),
    .inv_valid_i(inv_valid), .inv_ppn_i(inv_ppn),
    .q_pa_i(q_pa), .q_asid_i(q_asid),
    .q_hit_o(q_hit), .busy_o(busy), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [19:0] p, input logic [8:0] a, input logic m, input logic g);
    ins_ppn = p; ins_asid = a; ins_mega = m; ins_global = g; ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
  endtask

  task automatic qchk(input string tag, input int k, input logic [31:0] pa,
                      input logic [8:0] a, input logic exp);
    q_pa[k*32 +: 32] = pa;
    q_asid[k*9 +: 9] = a;
    #1;
    chk(tag, 32'(q_hit[k]), 32'(exp));
  endtask

  task automatic pulse_flush_all();
    flush_all = 1'b1;
    tick();
    flush_all = 1'b0;
  endtask

  task automatic start_flush_asid(input logic [8:0] a);
    flush_asid = a; flush_asid_valid = 1'b1;
    #1;
    chk("flush_asid_ready_idle", 32'(flush_asid_ready), 32'd1);
    tick();
    flush_asid_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hit", 32'(q_hit), 32'd0);
    chk("rst_ins_ready", 32'(ins_ready), 32'd1);
    chk("rst_flush_ready", 32'(flush_asid_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    ins(20'h12345, 9'd3, 1'b0, 1'b0);
    qchk("basic_hit", 0, 32'h12345ABC, 9'd3, 1'b1);
    qchk("basic_wrong_asid", 1, 32'h12345ABC, 9'd4, 1'b0);
    chk("basic_count", 32'(count), 32'd1);

    ins(20'h12C00, 9'd1, 1'b1, 1'b0);
    qchk("mega_hit", 0, 32'h12FFF000, 9'd1, 1'b1);
    qchk("mega_miss", 1, 32'h13000000, 9'd1, 1'b0);
    chk("mega_count", 32'(count), 32'd2);

    pulse_flush_all();
    chk("flush_all_count", 32'(count), 32'd0);
    qchk("flush_all_hit", 0, 32'h12345ABC, 9'd3, 1'b0);

    for (int i = 0; i < 16; i++) ins(20'h100 + 20'(i), 9'd7, 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'd16);
    ins(20'h200, 9'd7, 1'b0, 1'b0);
    qchk("repl17_old", 0, 32'h00100000, 9'd7, 1'b0);
    qchk("repl17_new", 1, 32'h00200000, 9'd7, 1'b1);
    chk("repl17_count", 32'(count), 32'd16);
    ins(20'h201, 9'd7, 1'b0, 1'b0);
    qchk("repl18_old", 0, 32'h00101000, 9'd7, 1'b0);
    qchk("repl18_keep", 1, 32'h00102000, 9'd7, 1'b1);
    ins(20'h105, 9'd7, 1'b0, 1'b0);
    chk("dup_count", 32'(count), 32'd16);
    ins(20'h202, 9'd7, 1'b0, 1'b0);
    qchk("dup_no_advance_old", 0, 32'h00102000, 9'd7, 1'b0);
    qchk("dup_no_advance_keep", 1, 32'h00103000, 9'd7, 1'b1);

    inv_valid = 1'b1; inv_ppn = 20'h105;
    #1;
    chk("ins_ready_inv", 32'(ins_ready), 32'd0);
    tick();
    inv_valid = 1'b0;
    chk("inv_count", 32'(count), 32'd15);
    ins(20'h300, 9'd7, 1'b0, 1'b0);
    chk("free_slot_count", 32'(count), 32'd16);
    qchk("free_slot_keep", 0, 32'h00103000, 9'd7, 1'b1);
    ins(20'h301, 9'd7, 1'b0, 1'b0);
    qchk("victim3_old", 0, 32'h00103000, 9'd7, 1'b0);
    qchk("victim3_keep", 1, 32'h00104000, 9'd7, 1'b1);

    pulse_flush_all();
    ins(20'h20, 9'd2, 1'b0, 1'b0);
    ins(20'h21, 9'd2, 1'b0, 1'b0);
    ins(20'h22, 9'd2, 1'b0, 1'b0);
    ins(20'h50, 9'd5, 1'b0, 1'b0);
    ins(20'h51, 9'd5, 1'b0, 1'b0);
    ins(20'h60, 9'd2, 1'b0, 1'b1);
    chk("asid_pre_count", 32'(count), 32'd6);
    start_flush_asid(9'd2);
    chk("sweep_busy", 32'(busy), 32'd1);
    chk("sweep_ins_ready", 32'(ins_ready), 32'd0);
    chk("sweep_flush_ready", 32'(flush_asid_ready), 32'd0);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("sweep_cycles", 32'(cyc), 32'd16);
    chk("sweep_count", 32'(count), 32'd3);
    qchk("sweep_global_hit", 0, 32'h00060000, 9'd9, 1'b1);
    qchk("sweep_other_asid", 1, 32'h00050000, 9'd5, 1'b1);
    qchk("sweep_cleared", 0, 32'h00020000, 9'd2, 1'b0);

    pulse_flush_all();
    ins(20'h70, 9'd6, 1'b0, 1'b0);
    ins(20'h71, 9'd6, 1'b0, 1'b0);
    start_flush_asid(9'd4);
    repeat (4) tick();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    chk("abort_pre_count", 32'(count), 32'd2);
    flush_all = 1'b1;
    ins_ppn = 20'h777; ins_asid = 9'd6; ins_mega = 1'b0; ins_global = 1'b0; ins_valid = 1'b1;
    #1;
    chk("abort_ins_ready", 32'(ins_ready), 32'd0);
    tick();
    flush_all = 1'b0; ins_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    qchk("abort_no_insert", 0, 32'h00777000, 9'd6, 1'b0);

    ins(20'h4444, 9'd1, 1'b0, 1'b0);
    ins(20'h4444, 9'd2, 1'b0, 1'b0);
    qchk("inv_pre_p0", 0, 32'h04444000, 9'd1, 1'b1);
    qchk("inv_pre_p1", 1, 32'h04444000, 9'd2, 1'b1);
    inv_valid = 1'b1; inv_ppn = 20'h4444;
    tick();
    inv_valid = 1'b0;
    qchk("inv_p0", 0, 32'h04444000, 9'd1, 1'b0);
    qchk("inv_p1", 1, 32'h04444000, 9'd2, 1'b0);
    chk("inv_both_count", 32'(count), 32'd0);

    ins(20'h90, 9'd3, 1'b0, 1'b0);
    start_flush_asid(9'd3);
    inv_valid = 1'b1; inv_ppn = 20'h90;
    tick();
    inv_valid = 1'b0;
    chk("inv_sweep_count", 32'(count), 32'd0);
    chk("inv_sweep_busy", 32'(busy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_page_tracker.md
EXEC_PAGE_TRACKER -- requirements
Module: exec_page_tracker

Interface
REQ-001 Parameter PPN_W, 20, physical page number width; PA width is PPN_W+12.
REQ-002 Parameter N, 16, number of tracked entries (power of two, >=2).
REQ-003 Parameter ASID_W, 9, address-space identifier width.
REQ-004 Parameter NQ, 2, number of independent query ports.
REQ-005 Parameter MEGA_BITS, 10, low PPN bits ignored for megapage entries.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 ins_valid_i / ins_ready_o  in/out  1  insert handshake; transfer when both high.
REQ-009 ins_ppn_i  in  PPN_W; ins_asid_i  in  ASID_W; ins_mega_i  in  1  megapage; ins_global_i  in  1  global (ASID-agnostic).
REQ-010 flush_all_i  in  1  single-cycle pulse; invalidate all entries (satp write, global sfence.vma).
REQ-011 flush_asid_valid_i / flush_asid_ready_o  in/out  1  per-ASID flush handshake; flush_asid_i  in  ASID_W.
REQ-012 inv_valid_i  in  1; inv_ppn_i  in  PPN_W  invalidate entries covering this PPN (store to exec page, W^X).
REQ-013 q_pa_i  in  NQ*PA_W; q_asid_i  in  NQ*ASID_W; port k uses slice k.
REQ-014 q_hit_o  out  NQ  port k PA lies in a valid executable page for its ASID.
REQ-015 busy_o  out  1  sweep in progress; count_o  out  $clog2(N)+1  number of valid entries.

Function
REQ-016 Entry: valid, ppn, asid, mega, global; all cleared on reset.
REQ-017 Entry matches (ppn P, asid A) when valid, (global or asid==A), and ppn==P (mega: upper PPN_W-MEGA_BITS bits equal).
REQ-018 q_hit_o[k] combinational, same cycle, OR of matches over all entries using q_pa_i[k] bits [PA_W-1:12].
REQ-019 FSM states IDLE, SWEEP; reset -> IDLE.
REQ-020 ins_ready_o = IDLE and !flush_all_i and !flush_asid_valid_i and !inv_valid_i.
REQ-021 Insert: exact duplicate (ppn, asid, mega, global all equal, valid) -> no allocation, no state change.
REQ-022 Insert otherwise: write lowest-index invalid entry; if none, overwrite entry at victim pointer and advance pointer by 1, wrapping N-1 -> 0.
REQ-023 Victim pointer advances only on full-CAM replacement; reset value 0; flush_all resets it to 0.
REQ-024 flush_asid_ready_o = IDLE and !flush_all_i; on transfer latch ASID, go SWEEP, sweep index = 0.
REQ-025 SWEEP: one entry per cycle; clear index i if valid, !global, asid==latched; after index N-1 return IDLE (N cycles in SWEEP).
REQ-026 busy_o = (state==SWEEP); queries during SWEEP reflect current, partially swept contents.
REQ-027 inv_valid_i: in the next cycle, clear every entry matching inv_ppn_i regardless of ASID/global, in any state; SWEEP continues.
REQ-028 flush_all_i: next cycle all entries invalid, state IDLE (aborts SWEEP), count_o = 0; highest priority over all other events.
REQ-029 Same-cycle inv and SWEEP clear of the same entry: entry invalid; no conflict.
REQ-030 count_o is registered popcount of valid bits, updated the cycle after any change.

Reset
REQ-031 While rst high: all valid bits 0, victim pointer 0, IDLE, q_hit_o = 0, busy_o = 0, count_o = 0, ins_ready_o and flush_asid_ready_o follow REQ-020/024 (1 when inputs idle).
REQ-032 rst asserted mid-SWEEP: immediate return to IDLE with all entries invalid; latched ASID discarded.

Verification
REQ-033 Insert ppn 0x12345 asid 3 -> next cycle query PA 0x12345ABC asid 3 hit=1, asid 4 hit=0, count_o=1.
REQ-034 Insert mega ppn 0x12C00 asid 1 -> query PA 0x12FFF000 asid 1 hit=1; PA 0x13000000 hit=0.
REQ-035 Fill N=16 distinct entries, insert 17th -> entry 0 replaced, count_o=16; 18th replaces entry 1; repeat of an existing entry -> no change.
REQ-036 Entries asid 2 (x3), asid 5 (x2), one global asid 2; flush_asid 2 -> busy_o high 16 cycles, then count_o=3, global still hits.
REQ-037 flush_all_i during cycle 5 of SWEEP with ins_valid_i high -> insert not accepted, busy_o 0 next cycle, count_o=0.
REQ-038 Same ppn inserted under asid 1 and 2, inv_ppn_i = that ppn -> both cleared next cycle; both query ports hit=0.
